// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx
//  Purpose  : 8-bit UART transmitter (start, 8 data LSB first, stop) with a
//             valid/ready byte handshake and a one-cycle tx_done pulse.
//             Optional even-parity bit enabled by macro UART_TX_PARITY_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       tx,
    output logic       tx_done
);

    localparam int BIT_PERIOD = CLK_FREQ / BAUD_RATE;
    localparam int CNT_W      = (BIT_PERIOD > 1) ? $clog2(BIT_PERIOD) : 1;
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(BIT_PERIOD - 1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] c_PARITY = 3'd3;
`endif
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]       state_q,      state_d;
    logic [CNT_W-1:0] cnt_q,        cnt_d;
    logic [2:0]       bit_idx_q,    bit_idx_d;
    logic [7:0]       shift_q,      shift_d;
    logic             tx_q,         tx_d;
    logic             data_ready_q, data_ready_d;
    logic             tx_done_q,    tx_done_d;
`ifdef UART_TX_PARITY_EN
    logic             parity_q,     parity_d;
`endif

    logic w_bit_end;
    assign w_bit_end = (cnt_q == c_CNT_LAST);

    // tx is computed one cycle ahead so the line itself comes straight from a flop
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        data_ready_d = data_ready_q;
`ifdef UART_TX_PARITY_EN
        parity_d     = parity_q;
`endif
        case (state_q)
            c_IDLE: begin
                tx_d         = 1'b1;
                data_ready_d = 1'b1;
                cnt_d        = '0;
                bit_idx_d    = '0;
                if (data_valid && data_ready_q) begin
                    shift_d      = data;
`ifdef UART_TX_PARITY_EN
                    parity_d     = ^data;
`endif
                    state_d      = c_START;
                    tx_d         = 1'b0;
                    data_ready_d = 1'b0;
                end
            end
            c_START: begin
                if (w_bit_end) begin
                    state_d   = c_DATA;
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            c_DATA: begin
                if (w_bit_end) begin
                    cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = c_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = c_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = {1'b0, shift_q[7:1]};
                        tx_d      = shift_q[1];
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`ifdef UART_TX_PARITY_EN
            c_PARITY: begin
                if (w_bit_end) begin
                    state_d = c_STOP;
                    cnt_d   = '0;
                    tx_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            c_STOP: begin
                tx_d = 1'b1;
                if (w_bit_end) begin
                    state_d      = c_IDLE;
                    cnt_d        = '0;
                    data_ready_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d      = c_IDLE;
                cnt_d        = '0;
                bit_idx_d    = '0;
                tx_d         = 1'b1;
                data_ready_d = 1'b0;
            end
        endcase
        // Registered pulse lands exactly on the final cycle of the stop bit
        tx_done_d = (state_d == c_STOP) && (cnt_d == c_CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= c_IDLE;
            cnt_q        <= '0;
            bit_idx_q    <= '0;
            shift_q      <= '0;
            tx_q         <= 1'b1;
            data_ready_q <= 1'b0;
            tx_done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            data_ready_q <= data_ready_d;
            tx_done_q    <= tx_done_d;
`ifdef UART_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    assign data_ready = data_ready_q;
    assign tx         = tx_q;
    assign tx_done    = tx_done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx
//  Purpose  : Self-checking bench for uart_tx against a frame-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int CLK_FREQ  = 50_000_000;
    localparam int BAUD_RATE = 115200;
    localparam int BP        = CLK_FREQ / BAUD_RATE;
`ifdef UART_TX_PARITY_EN
    localparam int FL = 11;
`else
    localparam int FL = 10;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       data_valid = 1'b0;
    logic       data_ready;
    logic       tx;
    logic       tx_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_start = 0;

    uart_tx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .tx_done    (tx_done)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Line level for each frame bit: start, data LSB first, optional parity, stop
    function automatic logic [10:0] model_frame(input int b);
        logic [10:0] f;
        int ones;
        f    = '0;
        ones = 0;
        f[0] = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f[k+1] = 1'((b / (1 << k)) % 2);
            ones   = ones + ((b / (1 << k)) % 2);
        end
        if (FL == 11) f[9] = 1'(ones % 2);
        f[FL-1] = 1'b1;
        return f;
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 50 && data_ready !== 1'b1; k++) @(negedge clk);
        check("ready_wait", 32'(data_ready), 32'd1);
    endtask

    // Called at a negedge; offers byte b and checks every cycle of its frame
    task automatic send_frame(input logic [7:0] b, input bit keep_valid,
                              input logic [7:0] next_b, input bit inject_busy,
                              input bit check_spacing);
        logic [10:0] f;
        f = model_frame(int'(b));
        wait_ready();
        data       = b;
        data_valid = 1'b1;
        @(posedge clk);
        for (int i = 0; i < FL * BP; i++) begin
            @(negedge clk);
            if (i == 0) begin
                if (check_spacing)
                    check("start_spacing", 32'(cyc - last_start), 32'(FL * BP + 1));
                last_start = cyc;
                if (keep_valid) begin
                    data = next_b;
                end else begin
                    data_valid = 1'b0;
                    data       = 8'($urandom);
                end
            end
            if (inject_busy && i == BP * 5 + 7) begin
                data_valid = 1'b1;
                data       = 8'hAA;
            end
            if (inject_busy && i == FL * BP - 3) data_valid = 1'b0;
            check($sformatf("tx[%02h] bit%0d cyc%0d", b, i / BP, i % BP), 32'(tx), 32'(f[i / BP]));
            check($sformatf("tx_done[%02h] cyc%0d", b, i), 32'(tx_done), 32'(i == FL * BP - 1));
            check($sformatf("ready_busy[%02h] cyc%0d", b, i), 32'(data_ready), 32'd0);
        end
        @(negedge clk);
        check("idle_ready", 32'(data_ready), 32'd1);
        check("idle_tx", 32'(tx), 32'd1);
        check("idle_done", 32'(tx_done), 32'd0);
    endtask

    initial begin
        // Reset with data_valid high: nothing may be accepted
        data_valid = 1'b1;
        data       = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx", 32'(tx), 32'd1);
            check("rst_ready", 32'(data_ready), 32'd0);
            check("rst_done", 32'(tx_done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", 32'(data_ready), 32'd1);
        check("post_rst_tx", 32'(tx), 32'd1);
        data_valid = 1'b0;
        @(negedge clk);
        check("rst_valid_ignored_tx", 32'(tx), 32'd1);

        send_frame(8'h55, 1'b0, 8'h00, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++)
            send_frame(8'($urandom_range(0, 255)), 1'b0, 8'h00, 1'b0, 1'b0);

        // Busy offer of 0xAA is ignored, then re-offered in idle
        send_frame(8'h3C, 1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("aa_not_queued_tx", 32'(tx), 32'd1);
        end
        send_frame(8'hAA, 1'b0, 8'h00, 1'b0, 1'b0);

        // Back-to-back with data_valid held
        for (int i = 0; i < 8; i++)
            send_frame(8'h30 + 8'(i), (i < 7), 8'h31 + 8'(i), 1'b0, (i > 0));

        // Reset during data bit 3 of 0x33
        wait_ready();
        data       = 8'h33;
        data_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        data_valid = 1'b0;
        repeat (4 * BP + 100) @(negedge clk);
        check("pre_rst_bit3", 32'(tx), 32'd0);
        rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("midrst_tx", 32'(tx), 32'd1);
            check("midrst_done", 32'(tx_done), 32'd0);
            check("midrst_ready", 32'(data_ready), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("midrst_release_ready", 32'(data_ready), 32'd1);
        for (int k = 0; k < 2 * BP; k++) begin
            @(negedge clk);
            check("abandoned_no_done", 32'(tx_done), 32'd0);
        end
        send_frame(8'h35, 1'b0, 8'h00, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
        send_frame(8'h33, 1'b0, 8'h00, 1'b0, 1'b0);
        send_frame(8'h31, 1'b0, 8'h00, 1'b0, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
